// File: rtl/mul_prod_accum.sv
`default_nettype none
// ============================================================================
// Module   : mul_prod_accum
// Purpose  : Registered, back-pressurable consumer for the Dadda multiplier
//            product stream. Sums a frame of unsigned products (closed by
//            prod_last) into a dot-product result and reports the beat count
//            and an overflow flag on a valid/ready result port.
// Ports    : clk, rst_n (async, active-low)
//            prod_in/prod_valid/prod_last/prod_ready : product input stream
//            res_data/res_count/res_ovf/res_valid/res_ready : result port
// Options  : MUL_ACCUM_SATURATE_EN - when defined, the accumulator clamps to
//            all ones on carry out instead of wrapping modulo 2^ACC_WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module mul_prod_accum #(
   parameter int PROD_WIDTH = 8,
   parameter int ACC_WIDTH  = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [PROD_WIDTH-1:0] prod_in,
   input  logic                  prod_valid,
   input  logic                  prod_last,
   output logic                  prod_ready,
   output logic [ACC_WIDTH-1:0]  res_data,
   output logic [CNT_WIDTH-1:0]  res_count,
   output logic                  res_ovf,
   output logic                  res_valid,
   input  logic                  res_ready
);

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t                 state_q,     state_d;
   logic [ACC_WIDTH-1:0]   acc_q,       acc_d;
   logic [CNT_WIDTH-1:0]   cnt_q,       cnt_d;
   logic                   ovf_q,       ovf_d;
   logic [ACC_WIDTH-1:0]   res_data_q,  res_data_d;
   logic [CNT_WIDTH-1:0]   res_count_q, res_count_d;
   logic                   res_ovf_q,   res_ovf_d;
   logic                   res_valid_q, res_valid_d;

   logic [ACC_WIDTH:0]     w_prod_ext;
   logic [ACC_WIDTH:0]     w_sum;
   logic                   w_carry;
   logic [ACC_WIDTH-1:0]   w_acc_next;
   logic [CNT_WIDTH-1:0]   w_cnt_inc;
   logic                   w_accept;

   // One extra bit on the adder exposes the carry out of the accumulator.
   assign w_prod_ext = {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, prod_in};
   assign w_sum      = {1'b0, acc_q} + w_prod_ext;
   assign w_carry    = w_sum[ACC_WIDTH];

`ifdef MUL_ACCUM_SATURATE_EN
   // Once clamped, any further non-zero beat carries again and re-clamps,
   // and zero beats leave all-ones untouched, so the clamp holds for the frame.
   assign w_acc_next = w_carry ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
   assign w_acc_next = w_sum[ACC_WIDTH-1:0];
`endif

   // Beat counter saturates at all ones rather than wrapping.
   assign w_cnt_inc  = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);

   assign w_accept   = prod_valid && (state_q == ACCUM);

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      res_data_d  = res_data_q;
      res_count_d = res_count_q;
      res_ovf_d   = res_ovf_q;
      res_valid_d = res_valid_q;

      case (state_q)
         ACCUM: begin
            if (w_accept) begin
               if (prod_last) begin
                  res_data_d  = w_acc_next;
                  res_count_d = w_cnt_inc;
                  res_ovf_d   = ovf_q | w_carry;
                  res_valid_d = 1'b1;
                  state_d     = HOLD;
                  // Frame state clears on the same edge the result is captured.
                  acc_d       = '0;
                  cnt_d       = '0;
                  ovf_d       = 1'b0;
               end else begin
                  acc_d       = w_acc_next;
                  cnt_d       = w_cnt_inc;
                  ovf_d       = ovf_q | w_carry;
               end
            end
         end
         HOLD: begin
            // res_valid is always high in HOLD, so res_ready alone completes it.
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ACCUM;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         res_data_q  <= '0;
         res_count_q <= '0;
         res_ovf_q   <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         res_data_q  <= res_data_d;
         res_count_q <= res_count_d;
         res_ovf_q   <= res_ovf_d;
         res_valid_q <= res_valid_d;
      end
   end

   // prod_ready is a pure function of state: no bypass from res_ready.
   assign prod_ready = (state_q == ACCUM);
   assign res_data   = res_data_q;
   assign res_count  = res_count_q;
   assign res_ovf    = res_ovf_q;
   assign res_valid  = res_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_prod_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_prod_accum
// Purpose  : Scoreboard bench for mul_prod_accum. A driver issues directed and
//            random product frames and pushes the expected frame result into
//            a queue; an independent monitor pops and compares on every result
//            handshake and checks hold stability and the ready/valid relation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_prod_accum;

   localparam int P = 8;
   localparam int A = 10;
   localparam int C = 3;
   localparam int MAXA = (1 << A) - 1;
   localparam int MAXC = (1 << C) - 1;

   logic          clk;
   logic          rst_n;
   logic [P-1:0]  prod_in;
   logic          prod_valid;
   logic          prod_last;
   logic          prod_ready;
   logic [A-1:0]  res_data;
   logic [C-1:0]  res_count;
   logic          res_ovf;
   logic          res_valid;
   logic          res_ready;

   mul_prod_accum #(
      .PROD_WIDTH (P),
      .ACC_WIDTH  (A),
      .CNT_WIDTH  (C)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .prod_in    (prod_in),
      .prod_valid (prod_valid),
      .prod_last  (prod_last),
      .prod_ready (prod_ready),
      .res_data   (res_data),
      .res_count  (res_count),
      .res_ovf    (res_ovf),
      .res_valid  (res_valid),
      .res_ready  (res_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [A-1:0] data;
      logic [C-1:0] cnt;
      logic         ovf;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   pushed = 0;
   int   popped = 0;
   int   f_total = 0;   // running arithmetic sum of the open frame
   int   f_n     = 0;   // beats in the open frame
   int   fbuf[$];
   int   rr_mode = 0;   // 0: random res_ready, otherwise main drives it

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference: exact integer sum of the frame, then wrap or clamp.
   function automatic exp_t model(input int sum, input int n);
      exp_t e;
      if (sum > MAXA) begin
`ifdef MUL_ACCUM_SATURATE_EN
         e.data = A'(MAXA);
`else
         e.data = A'(sum % (MAXA + 1));
`endif
         e.ovf = 1'b1;
      end else begin
         e.data = A'(sum);
         e.ovf  = 1'b0;
      end
      e.cnt = C'((n > MAXC) ? MAXC : n);
      return e;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic send_beat(input int v, input logic last, input int idle);
      int w;
      prod_valid = 1'b0;
      prod_in    = P'($urandom);
      prod_last  = 1'($urandom);
      repeat (idle) begin
         @(posedge clk); #1;
         prod_in   = P'($urandom);
         prod_last = 1'($urandom);
      end
      prod_valid = 1'b1;
      prod_in    = P'(v);
      prod_last  = last;
      w = 0;
      @(negedge clk);
      while (!prod_ready && w < 200) begin
         w++;
         @(negedge clk);
      end
      if (!prod_ready) begin
         check("beat_accept_timeout", 32'd0, 32'd1);
         prod_valid = 1'b0;
      end else begin
         @(posedge clk); #1;
         prod_valid = 1'b0;
         f_total += v;
         f_n++;
         if (last) begin
            exp_q.push_back(model(f_total, f_n));
            pushed++;
            f_total = 0;
            f_n     = 0;
            check("latency_res_valid", 32'(res_valid), 32'd1);
         end
      end
   endtask

   task automatic send_frame(input int idle_max);
      for (int i = 0; i < fbuf.size(); i++)
         send_beat(fbuf[i], (i == fbuf.size() - 1), $urandom_range(0, idle_max));
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 500) begin
         @(posedge clk); #1;
         w++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   always @(posedge clk) begin
      #1;
      if (rr_mode == 0) res_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: handshake occurs at the posedge following a sample with both high.
   logic                 held;
   logic [A+C:0]         held_word;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         check("ready_vs_valid", 32'(prod_ready), 32'(!res_valid));
         if (res_valid) begin
            if (held) check("hold_stable", 32'({res_data, res_count, res_ovf}), 32'(held_word));
            if (res_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_result: got data %0d expected none", res_data);
               end else begin
                  e = exp_q.pop_front();
                  popped++;
                  check("res_data",  32'(res_data),  32'(e.data));
                  check("res_count", 32'(res_count), 32'(e.cnt));
                  check("res_ovf",   32'(res_ovf),   32'(e.ovf));
               end
               held = 1'b0;
            end else begin
               held      = 1'b1;
               held_word = {res_data, res_count, res_ovf};
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   initial begin
      held       = 1'b0;
      held_word  = '0;
      rst_n      = 1'b0;
      prod_valid = 1'b0;
      prod_in    = '0;
      prod_last  = 1'b0;
      res_ready  = 1'b0;
      rr_mode    = 2;

      #12;
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data",  32'(res_data),  32'd0);
      check("rst_res_count", 32'(res_count), 32'd0);
      check("rst_res_ovf",   32'(res_ovf),   32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_prod_ready", 32'(prod_ready), 32'd1);
      res_ready = 1'b1;

      // Directed frames with the result port always ready.
      fbuf = '{6, 15, 225};        send_frame(0);
      fbuf = '{9};                 send_frame(0);
      fbuf = '{0, 0};              send_frame(1);
      fbuf = '{225, 225, 225, 225, 225}; send_frame(1);
      fbuf = '{3};                 send_frame(0);
      fbuf = '{1, 1, 1, 1, 1, 1, 1, 1, 1}; send_frame(0);
      drain();

      // Back-pressure: result held while a new beat waits.
      rr_mode   = 1;
      res_ready = 1'b0;
      fbuf = '{10, 20};            send_frame(0);
      prod_valid = 1'b1;
      prod_in    = 8'd5;
      prod_last  = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("hold_prod_ready", 32'(prod_ready), 32'd0);
         check("hold_res_data",   32'(res_data),   32'd30);
      end
      @(posedge clk); #1;
      rr_mode   = 2;
      res_ready = 1'b1;
      send_beat(5, 1'b1, 0);
      drain();

      // Asynchronous reset in the middle of a frame.
      send_beat(50, 1'b0, 0);
      send_beat(60, 1'b0, 0);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(res_valid), 32'd0);
      check("async_rst_data",  32'(res_data),  32'd0);
      check("async_rst_count", 32'(res_count), 32'd0);
      f_total = 0;
      f_n     = 0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      send_beat(7, 1'b1, 0);
      drain();

      // Random frames with random gaps and random result back-pressure.
      rr_mode = 0;
      for (int f = 0; f < 40; f++) begin
         int len;
         int kind;
         len  = $urandom_range(1, 10);
         kind = $urandom_range(0, 2);
         fbuf.delete();
         for (int b = 0; b < len; b++) begin
            case (kind)
               0:       fbuf.push_back($urandom_range(0, 20));
               1:       fbuf.push_back($urandom_range(200, 255));
               default: fbuf.push_back($urandom_range(0, 255));
            endcase
         end
         send_frame(2);
      end
      rr_mode   = 2;
      res_ready = 1'b1;
      drain();
      check("results_popped", 32'(popped), 32'(pushed));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
